// File: rtl/text_overlay_pkg.sv
// Shared constants for the character-cell text overlay: glyph geometry,
// character codes, write/clear FSM state encoding and a width helper.
package text_overlay_pkg;

    localparam int GLYPH_W = 8;
    localparam int GLYPH_H = 16;

    localparam logic [6:0] CH_SPACE      = 7'h00;
    localparam logic [6:0] CH_COLON      = 7'h3a;
    localparam logic [6:0] CH_DIGIT_BASE = 7'h30;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_IDLE  = 1'b1;

    // Ceiling log2, never below 1 so a single line/column still gets a port bit.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1)
            r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/text_char_buffer.sv
// Character store: one write port, one synchronous read port, 7-bit codes.
module text_char_buffer #(
    parameter int AW = 7
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [6:0]    wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [6:0]    rdata
);

    logic [6:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    // Only the read register is reset; contents are wiped by the clear sweep.
    always_ff @(posedge clk) begin
        if (reset)
            rdata <= 7'h00;
        else if (re)
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/text_overlay_engine.sv
// Text overlay: write/clear FSM, line colours and 3-stage pixel pipeline to the
// font ROM. Optional cursor blink enabled by TEXT_OVERLAY_CURSOR_BLINK_EN.
module text_overlay_engine
    import text_overlay_pkg::*;
#(
    parameter int NUM_LINES      = 4,
    parameter int CHARS_PER_LINE = 32,
    parameter int SCALE_LOG2     = 1,
    parameter int ORIGIN_X       = 0,
    parameter int ORIGIN_Y       = 32,
    parameter int BLINK_FRAMES   = 30,
    localparam int LW = clog2(NUM_LINES),
    localparam int CW = clog2(CHARS_PER_LINE)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pixel_tick,
    input  logic [9:0]    pix_x,
    input  logic [9:0]    pix_y,
    input  logic          wr_en,
    input  logic [LW-1:0] wr_line,
    input  logic [CW-1:0] wr_col,
    input  logic [6:0]    wr_char,
    output logic          wr_ready,
    input  logic          clr_req,
    input  logic          color_we,
    input  logic [LW-1:0] color_line,
    input  logic [2:0]    color_rgb,
    input  logic [LW-1:0] cur_line,
    input  logic [CW-1:0] cur_col,
    output logic [10:0]   rom_addr,
    input  logic [7:0]    font_word,
    output logic          text_on,
    output logic [2:0]    text_rgb
);

    localparam int AW    = LW + CW;
    localparam int DEPTH = NUM_LINES * CHARS_PER_LINE;
    localparam int GW    = GLYPH_W << SCALE_LOG2;
    localparam int GH    = GLYPH_H << SCALE_LOG2;

    localparam logic [12:0] X_LO   = 13'(ORIGIN_X);
    localparam logic [12:0] Y_LO   = 13'(ORIGIN_Y);
    localparam logic [11:0] X_SPAN = 12'(CHARS_PER_LINE * GW);
    localparam logic [11:0] Y_SPAN = 12'(NUM_LINES * GH);

    logic [0:0]    state;
    logic [AW-1:0] clr_cnt;
    logic          buf_we;
    logic [AW-1:0] buf_waddr;
    logic [6:0]    buf_wdata;
    logic [6:0]    buf_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == AW'(DEPTH - 1))
                        state <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (clr_req) begin
                        state   <= ST_CLEAR;
                        clr_cnt <= '0;
                    end
                end
                default: state <= ST_CLEAR;
            endcase
        end
    end

    assign wr_ready = (state == ST_IDLE);

    // A clear request in the same cycle as a write drops the write.
    always_comb begin
        buf_we    = 1'b0;
        buf_waddr = clr_cnt;
        buf_wdata = CH_SPACE;
        if (!reset) begin
            if (state == ST_CLEAR) begin
                buf_we = 1'b1;
            end else if (wr_en && !clr_req) begin
                buf_we    = 1'b1;
                buf_waddr = {wr_line, wr_col};
                buf_wdata = wr_char;
            end
        end
    end

    logic [2:0] line_rgb [2**LW];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2**LW; i++)
                line_rgb[i] <= 3'b111;
        end else if (color_we) begin
            line_rgb[color_line] <= color_rgb;
        end
    end

    // Extra top bit of rx/ry flags a pixel left of / above the origin.
    logic [12:0]   rx, ry;
    logic          dec_hit;
    logic [LW-1:0] dec_line;
    logic [CW-1:0] dec_col;
    logic [3:0]    dec_row;
    logic [2:0]    dec_bit;

    assign rx       = {3'b000, pix_x} - X_LO;
    assign ry       = {3'b000, pix_y} - Y_LO;
    assign dec_hit  = !rx[12] && (rx[11:0] < X_SPAN) && !ry[12] && (ry[11:0] < Y_SPAN);
    assign dec_col  = CW'(rx >> (3 + SCALE_LOG2));
    assign dec_bit  = 3'(rx >> SCALE_LOG2);
    assign dec_line = LW'(ry >> (4 + SCALE_LOG2));
    assign dec_row  = 4'(ry >> SCALE_LOG2);

    text_char_buffer #(.AW(AW)) u_buf (
        .clk   (clk),
        .reset (reset),
        .we    (buf_we),
        .waddr (buf_waddr),
        .wdata (buf_wdata),
        .re    (pixel_tick),
        .raddr ({dec_line, dec_col}),
        .rdata (buf_rdata)
    );

    logic          s1_hit, s2_hit;
    logic [LW-1:0] s1_line;
    logic [3:0]    s1_row;
    logic [2:0]    s1_bit, s2_bit;
    logic [2:0]    s2_rgb;
    logic          cursor_mask;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_hit   <= 1'b0;
            s1_line  <= '0;
            s1_row   <= '0;
            s1_bit   <= '0;
            s2_hit   <= 1'b0;
            s2_bit   <= '0;
            s2_rgb   <= '0;
            rom_addr <= '0;
            text_on  <= 1'b0;
            text_rgb <= '0;
        end else if (pixel_tick) begin
            s1_hit   <= dec_hit;
            s1_line  <= dec_line;
            s1_row   <= dec_row;
            s1_bit   <= dec_bit;
            rom_addr <= {buf_rdata, s1_row};
            s2_hit   <= s1_hit;
            s2_bit   <= s1_bit;
            s2_rgb   <= line_rgb[s1_line];
            text_on  <= s2_hit;
            text_rgb <= (s2_hit && (font_word[~s2_bit] ^ cursor_mask)) ? s2_rgb : 3'b000;
        end
    end

`ifdef TEXT_OVERLAY_CURSOR_BLINK_EN
    logic [15:0] frame_cnt;
    logic        blink_visible;
    logic        s1_cur, s2_cur;

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt     <= '0;
            blink_visible <= 1'b1;
        end else if (pixel_tick && pix_x == 10'd0 && pix_y == 10'd0) begin
            if (frame_cnt == 16'(BLINK_FRAMES - 1)) begin
                frame_cnt     <= '0;
                blink_visible <= !blink_visible;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_cur <= 1'b0;
            s2_cur <= 1'b0;
        end else if (pixel_tick) begin
            s1_cur <= (dec_line == cur_line) && (dec_col == cur_col);
            s2_cur <= s1_cur;
        end
    end

    assign cursor_mask = s2_cur && blink_visible;
`else
    localparam int unused_blink_frames = BLINK_FRAMES;
    logic unused_cursor;
    assign unused_cursor = ^{cur_line, cur_col};
    assign cursor_mask   = 1'b0;
`endif

endmodule

// File: tb/tb_text_overlay_engine.sv
// Randomised bench for text_overlay_engine against a per-pixel behavioural model.
module tb_text_overlay_engine;

    localparam int NL = 4, CPL = 32, SC = 2, OX = 0, OY = 32;
    localparam int GW = 8 * SC, GH = 16 * SC;
    localparam int MAXE = 4096;

    logic        clk = 1'b0;
    logic        reset, pixel_tick;
    logic [9:0]  pix_x, pix_y;
    logic        wr_en;
    logic [1:0]  wr_line;
    logic [4:0]  wr_col;
    logic [6:0]  wr_char;
    logic        wr_ready;
    logic        clr_req, color_we;
    logic [1:0]  color_line;
    logic [2:0]  color_rgb;
    logic [1:0]  cur_line;
    logic [4:0]  cur_col;
    logic [10:0] rom_addr;
    logic [7:0]  font_word;
    logic        text_on;
    logic [2:0]  text_rgb;

    always #5 clk = ~clk;

    text_overlay_engine #(
        .NUM_LINES(NL), .CHARS_PER_LINE(CPL), .SCALE_LOG2(1),
        .ORIGIN_X(OX), .ORIGIN_Y(OY), .BLINK_FRAMES(30)
    ) dut (
        .clk(clk), .reset(reset), .pixel_tick(pixel_tick), .pix_x(pix_x), .pix_y(pix_y),
        .wr_en(wr_en), .wr_line(wr_line), .wr_col(wr_col), .wr_char(wr_char),
        .wr_ready(wr_ready), .clr_req(clr_req), .color_we(color_we),
        .color_line(color_line), .color_rgb(color_rgb), .cur_line(cur_line),
        .cur_col(cur_col), .rom_addr(rom_addr), .font_word(font_word),
        .text_on(text_on), .text_rgb(text_rgb)
    );

    int errors = 0, checks = 0;

    // Reference contents of the character buffer and line colours.
    logic [6:0] m_mem [NL][CPL];
    logic [2:0] m_rgb [NL];

    // External font ROM: an arbitrary fixed pattern, or a forced word for directed cases.
    logic       font_force;
    logic [7:0] font_forced;

    function automatic logic [7:0] fontf(input logic [6:0] c, input logic [3:0] r);
        return (8'(c) * 8'd37) ^ {r, ~r} ^ 8'h5a;
    endfunction

    always_comb font_word = font_force ? font_forced : fontf(rom_addr[10:4], rom_addr[3:0]);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-tick expectation entries, indexed by pixel_tick number.
    bit         e_hit  [MAXE];
    logic [6:0] e_char [MAXE];
    int         e_line [MAXE], e_row [MAXE], e_bit [MAXE];
    logic [2:0] e_rgbc [MAXE];
    logic [7:0] e_font [MAXE];
    int         n_ent = 0, n_edge = 0;

    task automatic tick(input int x, input int y);
        bit h;
        h = (x >= OX) && (x < OX + CPL * GW) && (y >= OY) && (y < OY + NL * GH);
        if (n_ent < MAXE) begin
            e_hit[n_ent]  = h;
            e_line[n_ent] = h ? (y - OY) / GH : 0;
            e_row[n_ent]  = h ? ((y - OY) / SC) % 16 : 0;
            e_bit[n_ent]  = h ? ((x - OX) / SC) % 8 : 0;
            e_char[n_ent] = h ? m_mem[(y - OY) / GH][(x - OX) / GW] : 7'h00;
        end
        n_ent++;
        pix_x = 10'(x);
        pix_y = 10'(y);
        pixel_tick = 1'b1;
        @(negedge clk);
        pixel_tick = 1'b0;
        @(negedge clk);
    endtask

    // Single compare process: after each pixel_tick edge, rom_addr reflects the
    // pixel of two ticks ago and text_on/text_rgb the pixel of three ticks ago.
    always @(posedge clk) begin
        int k;
        logic [2:0] exp_rgb;
        if (!reset && pixel_tick) begin
            k = n_edge;
            n_edge++;
            if (k >= 1 && k - 1 < MAXE) e_rgbc[k-1] = m_rgb[e_line[k-1]];
            if (k >= 2 && k - 2 < MAXE)
                e_font[k-2] = font_force ? font_forced : fontf(e_char[k-2], 4'(e_row[k-2]));
            #1;
            if (k >= 1 && k - 1 < MAXE && e_hit[k-1])
                check("rom_addr", 32'(rom_addr), 32'({e_char[k-1], 4'(e_row[k-1])}));
            if (k >= 2 && k - 2 < MAXE) begin
                exp_rgb = (e_hit[k-2] && e_font[k-2][7 - e_bit[k-2]]) ? e_rgbc[k-2] : 3'b000;
                check("text_on", 32'(text_on), 32'(e_hit[k-2]));
                check("text_rgb", 32'(text_rgb), 32'(exp_rgb));
            end
        end
    end

    task automatic write_char(input int l, input int c, input logic [6:0] ch);
        wr_line = 2'(l); wr_col = 5'(c); wr_char = ch; wr_en = 1'b1;
        m_mem[l][c] = ch;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic write_color(input int l, input logic [2:0] v);
        color_line = 2'(l); color_rgb = v; color_we = 1'b1;
        m_rgb[l] = v;
        @(negedge clk);
        color_we = 1'b0;
    endtask

    task automatic model_clear();
        for (int l = 0; l < NL; l++)
            for (int c = 0; c < CPL; c++)
                m_mem[l][c] = 7'h00;
    endtask

    // Counts clock edges until wr_ready, starting from 'already' edges seen.
    task automatic wait_ready(input int already, input string name);
        int n;
        n = already;
        while (wr_ready !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(n), 32'd128);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; pixel_tick = 1'b0; pix_x = '0; pix_y = '0;
        wr_en = 1'b0; wr_line = '0; wr_col = '0; wr_char = '0; clr_req = 1'b0;
        color_we = 1'b0; color_line = '0; color_rgb = '0; cur_line = '0; cur_col = '0;
        font_force = 1'b0; font_forced = 8'h00;
        model_clear();
        for (int l = 0; l < NL; l++) m_rgb[l] = 3'b111;

        // Reset, then a second reset mid-clear restarts the sweep.
        @(negedge clk);
        reset = 1'b0;
        repeat (50) @(negedge clk);
        check("ready_mid_clear", 32'(wr_ready), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("rst_wr_ready", 32'(wr_ready), 32'd0);
        check("rst_rom_addr", 32'(rom_addr), 32'd0);
        check("rst_text_on", 32'(text_on), 32'd0);
        check("rst_text_rgb", 32'(text_rgb), 32'd0);
        reset = 1'b0;
        wait_ready(0, "clear_len_reset");

        // Every cell of the window reads blank after the clear.
        for (int l = 0; l < NL; l++)
            for (int c = 0; c < CPL; c++)
                tick(OX + c * GW + $urandom_range(0, GW - 1), OY + l * GH + $urandom_range(0, GH - 1));

        // Directed: 'A' at (0,0), latency 2 ticks to rom_addr, 3 to text.
        write_char(0, 0, 7'h41);
        font_force = 1'b1; font_forced = 8'h80;
        tick(0, 32);
        tick(600, 0);
        check("lit_rom_addr_41", 32'(rom_addr), 32'h410);
        tick(600, 0);
        check("lit_text_on_41", 32'(text_on), 32'd1);
        check("lit_text_rgb_41", 32'(text_rgb), 32'd7);

        // Directed: scaled glyph at line 1 col 2 with line colour 001.
        write_char(1, 2, 7'h30);
        write_color(1, 3'b001);
        font_forced = 8'h40;
        tick(35, 69);
        tick(600, 0);
        check("lit_rom_addr_30", 32'(rom_addr), 32'h302);
        tick(600, 0);
        check("lit_text_rgb_30", 32'(text_rgb), 32'd1);
        font_forced = 8'hbf;
        tick(35, 69);
        tick(600, 0);
        tick(600, 0);
        check("lit_text_on_bit_off", 32'(text_on), 32'd1);
        check("lit_text_rgb_bit_off", 32'(text_rgb), 32'd0);

        // Directed: just outside the window on both axes.
        font_forced = 8'hff;
        tick(0, 31);
        tick(512, 32);
        tick(600, 0);
        check("lit_out_y_on", 32'(text_on), 32'd0);
        check("lit_out_y_rgb", 32'(text_rgb), 32'd0);
        tick(600, 0);
        check("lit_out_x_on", 32'(text_on), 32'd0);
        check("lit_out_x_rgb", 32'(text_rgb), 32'd0);
        tick(511, 159);
        tick(600, 0);
        tick(600, 0);
        check("lit_corner_on", 32'(text_on), 32'd1);
        font_force = 1'b0;

        // Random content, colours and pixels.
        for (int i = 0; i < 40; i++)
            write_char($urandom_range(0, NL - 1), $urandom_range(0, CPL - 1), 7'($urandom_range(0, 127)));
        for (int l = 0; l < NL; l++)
            write_color(l, 3'($urandom_range(0, 7)));
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) != 0)
                tick($urandom_range(0, 511), $urandom_range(32, 159));
            else
                tick($urandom_range(0, 639), $urandom_range(0, 199));
        end

        // Clear and write in the same cycle: clear wins; writes during clear are dropped.
        wr_line = 2'd0; wr_col = 5'd0; wr_char = 7'h55; wr_en = 1'b1; clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        model_clear();
        wr_line = 2'd1; wr_col = 5'd1; wr_char = 7'h7f;
        for (int i = 0; i < 3; i++) begin
            check("ready_during_clear", 32'(wr_ready), 32'd0);
            @(negedge clk);
        end
        wr_en = 1'b0;
        wait_ready(3, "clear_len_request");
        font_force = 1'b1; font_forced = 8'hff;
        tick(0, 32);
        tick(16, 64);
        check("lit_cleared_00", 32'(rom_addr[10:4]), 32'd0);
        tick(600, 0);
        check("lit_cleared_11", 32'(rom_addr[10:4]), 32'd0);
        tick(600, 0);
        font_force = 1'b0;
        for (int i = 0; i < 40; i++)
            tick($urandom_range(0, 511), $urandom_range(32, 159));

        // Reset after activity returns outputs to zero.
        reset = 1'b1;
        @(negedge clk);
        check("rst2_rom_addr", 32'(rom_addr), 32'd0);
        check("rst2_text_on", 32'(text_on), 32'd0);
        check("rst2_text_rgb", 32'(text_rgb), 32'd0);
        check("rst2_wr_ready", 32'(wr_ready), 32'd0);
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
